pa_iu_bju_redirect: RTL and testbench

//  Downstream of the EX1 address generator. Takes the branch/jump target (ag_bju_pc),
//  the condition result and the prediction, and decides whether to redirect.
//  On a mispredict it registers a redirect request, holds it to IFU under a valid/ready

---
 rtl/pa_iu_bju_pkg.sv | 18 +
 rtl/pa_iu_bju_redirect.sv | 101 ++++++++++
 tb/tb_pa_iu_bju_redirect.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pa_iu_bju_pkg.sv
// Shared encodings for the BJU redirect path: instruction types, FSM states, and the
// sequential-PC helper.
package pa_iu_bju_pkg;

    localparam logic [1:0] BJU_TYPE_BR    = 2'b00;
    localparam logic [1:0] BJU_TYPE_JAL   = 2'b01;
    localparam logic [1:0] BJU_TYPE_JALR  = 2'b10;
    localparam logic [1:0] BJU_TYPE_AUIPC = 2'b11;

    localparam logic [0:0] REDIR_IDLE = 1'b0;
    localparam logic [0:0] REDIR_REQ  = 1'b1;

    // Fall-through PC; a dedicated adder, independent of the AG adder.
    function automatic logic [31:0] seq_pc_calc(input logic [31:0] cur_pc, input logic inst_32);
        return cur_pc + (inst_32 ? 32'd4 : 32'd2);
    endfunction

endpackage

// File: rtl/pa_iu_bju_redirect.sv
// EX1 branch-resolution redirect: decides mispredict/misalign, holds a redirect request
// to IFU under valid/ready, flags EX1 wrong-path while pending, counts mispredicts.
module pa_iu_bju_redirect
    import pa_iu_bju_pkg::*;
#(
    parameter int RVC   = 1,
    parameter int CNT_W = 16
) (
    input  logic             cpuclk,
    input  logic             cpurst_b,
    input  logic             ex1_bju_vld,
    input  logic [1:0]       ex1_bju_type,
    input  logic             ex1_cmp_taken,
    input  logic             ex1_pred_taken,
    input  logic             ex1_inst_32,
    input  logic             ex1_stall,
    input  logic [31:0]      ag_bju_pc,
    input  logic [31:0]      iu_ex1_cur_pc,
    input  logic             rtu_iu_flush,
    input  logic             ifu_iu_redir_ready,
    output logic             iu_ifu_redir_vld,
    output logic [31:0]      iu_ifu_redir_pc,
    output logic             iu_ex1_wrong_path,
    output logic             iu_rtu_bju_expt_vld,
    output logic [31:0]      iu_rtu_bju_expt_tval,
    output logic [CNT_W-1:0] iu_hpcp_misp_cnt,
    output logic [0:0]       redir_state
);

    // Handshake: iu_ifu_redir_vld/pc are held stable until a cycle with
    // ifu_iu_redir_ready=1 (transfer) or rtu_iu_flush=1 (withdrawn); ready while
    // vld=0 has no effect.

    logic [0:0]       state;
    logic [31:0]      redir_pc;
    logic             expt_vld;
    logic [31:0]      expt_tval;
    logic [CNT_W-1:0] misp_cnt;

    logic        act_taken;
    logic        mispred;
    logic        misalign;
    logic        capture;
    logic [31:0] seq_pc;

    always_comb begin
        act_taken = (ex1_bju_type == BJU_TYPE_BR) ? ex1_cmp_taken
                                                  : (ex1_bju_type != BJU_TYPE_AUIPC);
        seq_pc    = seq_pc_calc(iu_ex1_cur_pc, ex1_inst_32);
        mispred   = ((ex1_bju_type == BJU_TYPE_BR) && (act_taken != ex1_pred_taken))
                  || ((ex1_bju_type == BJU_TYPE_JAL) && !ex1_pred_taken)
                  || (ex1_bju_type == BJU_TYPE_JALR);
        misalign  = (RVC == 0) && act_taken && ag_bju_pc[1]
                  && (ex1_bju_type != BJU_TYPE_AUIPC);
        capture   = ex1_bju_vld && !ex1_stall && !rtu_iu_flush && (state == REDIR_IDLE);
    end

    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            state     <= REDIR_IDLE;
            redir_pc  <= 32'd0;
            expt_vld  <= 1'b0;
            expt_tval <= 32'd0;
            misp_cnt  <= '0;
        end else begin
            expt_vld <= 1'b0;
            case (state)
                REDIR_IDLE: begin
                    // A misaligned target raises the exception instead of redirecting.
                    if (capture && misalign) begin
                        expt_vld  <= 1'b1;
                        expt_tval <= ag_bju_pc;
                    end else if (capture && mispred) begin
                        state    <= REDIR_REQ;
                        redir_pc <= act_taken ? ag_bju_pc : seq_pc;
                    end
                end
                REDIR_REQ: begin
                    if (rtu_iu_flush) begin
                        state <= REDIR_IDLE;
                    end else if (ifu_iu_redir_ready) begin
                        state <= REDIR_IDLE;
                        if (misp_cnt != {CNT_W{1'b1}}) begin
                            misp_cnt <= misp_cnt + 1'b1;
                        end
                    end
                end
                default: state <= REDIR_IDLE;
            endcase
        end
    end

    assign iu_ifu_redir_vld     = (state == REDIR_REQ);
    assign iu_ifu_redir_pc      = (state == REDIR_REQ) ? redir_pc : 32'd0;
    assign iu_ex1_wrong_path    = (state == REDIR_REQ);
    assign iu_rtu_bju_expt_vld  = expt_vld;
    assign iu_rtu_bju_expt_tval = expt_vld ? expt_tval : 32'd0;
    assign iu_hpcp_misp_cnt     = misp_cnt;
    assign redir_state          = state;

endmodule

// File: tb/tb_pa_iu_bju_redirect.sv
// Directed bench for pa_iu_bju_redirect: two instances (RVC=1/CNT_W=16 and RVC=0/CNT_W=2)
// share stimulus and are compared every cycle against a rule-level model.
module tb_pa_iu_bju_redirect;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        vld, cmp, pred, i32, stall, flush, ready;
    logic [1:0]  typ;
    logic [31:0] ag, cur;

    logic        vld_a, wp_a, ev_a, vld_b, wp_b, ev_b;
    logic [31:0] pc_a, tv_a, pc_b, tv_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [0:0]  st_a, st_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pa_iu_bju_redirect #(.RVC(1), .CNT_W(16)) dut_a (
        .cpuclk(clk), .cpurst_b(rst_b), .ex1_bju_vld(vld), .ex1_bju_type(typ),
        .ex1_cmp_taken(cmp), .ex1_pred_taken(pred), .ex1_inst_32(i32), .ex1_stall(stall),
        .ag_bju_pc(ag), .iu_ex1_cur_pc(cur), .rtu_iu_flush(flush), .ifu_iu_redir_ready(ready),
        .iu_ifu_redir_vld(vld_a), .iu_ifu_redir_pc(pc_a), .iu_ex1_wrong_path(wp_a),
        .iu_rtu_bju_expt_vld(ev_a), .iu_rtu_bju_expt_tval(tv_a), .iu_hpcp_misp_cnt(cnt_a),
        .redir_state(st_a));

    pa_iu_bju_redirect #(.RVC(0), .CNT_W(2)) dut_b (
        .cpuclk(clk), .cpurst_b(rst_b), .ex1_bju_vld(vld), .ex1_bju_type(typ),
        .ex1_cmp_taken(cmp), .ex1_pred_taken(pred), .ex1_inst_32(i32), .ex1_stall(stall),
        .ag_bju_pc(ag), .iu_ex1_cur_pc(cur), .rtu_iu_flush(flush), .ifu_iu_redir_ready(ready),
        .iu_ifu_redir_vld(vld_b), .iu_ifu_redir_pc(pc_b), .iu_ex1_wrong_path(wp_b),
        .iu_rtu_bju_expt_vld(ev_b), .iu_rtu_bju_expt_tval(tv_b), .iu_hpcp_misp_cnt(cnt_b),
        .redir_state(st_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: index 0 = dut_a, 1 = dut_b ----------------
    logic        m_pend[2];
    logic [31:0] m_pc[2];
    int          m_cnt[2];
    logic        m_expt[2];
    logic [31:0] m_tval[2];
    logic        m_rvc[2]  = '{1'b1, 1'b0};
    int          m_max[2]  = '{65535, 3};

    always @(posedge clk) begin
        logic tk, mis, mal;
        tk  = (typ == 2'd0) ? cmp : (typ != 2'd3);
        mis = (typ == 2'd0) ? (tk != pred) : (typ == 2'd1) ? !pred : (typ == 2'd2);
        for (int i = 0; i < 2; i++) begin
            mal = !m_rvc[i] && tk && ag[1];
            if (!rst_b) begin
                m_pend[i] = 1'b0; m_pc[i] = 32'd0; m_cnt[i] = 0;
                m_expt[i] = 1'b0; m_tval[i] = 32'd0;
            end else begin
                m_expt[i] = 1'b0;
                if (m_pend[i]) begin
                    if (flush) m_pend[i] = 1'b0;
                    else if (ready) begin
                        m_pend[i] = 1'b0;
                        if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                    end
                end else if (vld && !stall && !flush) begin
                    if (mal) begin
                        m_expt[i] = 1'b1;
                        m_tval[i] = ag;
                    end else if (mis) begin
                        m_pend[i] = 1'b1;
                        m_pc[i]   = tk ? ag : cur + (i32 ? 32'd4 : 32'd2);
                    end
                end
            end
        end
    end

    // Compare process: every negedge after the first clock edge.
    always @(negedge clk) begin
        chk("a_vld",  {31'd0, vld_a}, {31'd0, m_pend[0]});
        chk("a_pc",   pc_a, m_pend[0] ? m_pc[0] : 32'd0);
        chk("a_wp",   {31'd0, wp_a}, {31'd0, m_pend[0]});
        chk("a_expt", {31'd0, ev_a}, {31'd0, m_expt[0]});
        chk("a_tval", tv_a, m_expt[0] ? m_tval[0] : 32'd0);
        chk("a_cnt",  {16'd0, cnt_a}, m_cnt[0]);
        chk("b_vld",  {31'd0, vld_b}, {31'd0, m_pend[1]});
        chk("b_pc",   pc_b, m_pend[1] ? m_pc[1] : 32'd0);
        chk("b_wp",   {31'd0, wp_b}, {31'd0, m_pend[1]});
        chk("b_expt", {31'd0, ev_b}, {31'd0, m_expt[1]});
        chk("b_tval", tv_b, m_expt[1] ? m_tval[1] : 32'd0);
        chk("b_cnt",  {30'd0, cnt_b}, m_cnt[1]);
    end

    // ---------------- driver ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] t, input logic c, input logic p, input logic w,
                         input logic [31:0] pc, input logic [31:0] a);
        vld = 1'b1; typ = t; cmp = c; pred = p; i32 = w; cur = pc; ag = a;
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; vld = 1'b0; typ = 2'd0; cmp = 1'b0; pred = 1'b0; i32 = 1'b1;
        stall = 1'b0; flush = 1'b0; ready = 1'b0; ag = 32'd0; cur = 32'd0;
        cycles(2);
        chk("rst_vld", {31'd0, vld_a}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
        rst_b = 1'b1;
        cycles(1);

        // 1: taken branch predicted not-taken, accepted on first cycle
        issue(2'b00, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000);
        chk("t1_vld", {31'd0, vld_a}, 32'd1);
        chk("t1_pc", pc_a, 32'h2000);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        chk("t1_idle", {31'd0, vld_a}, 32'd0);
        chk("t1_cnt", {16'd0, cnt_a}, 32'd1);

        // 2: not-taken 16-bit branch predicted taken, ready withheld 3 cycles
        issue(2'b00, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h1800);
        chk("t2_pc", pc_b, 32'h1002);
        cycles(3);
        chk("t2_hold", pc_a, 32'h1002);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        chk("t2_clr", {31'd0, vld_a}, 32'd0);

        // 3: jalr, flush together with ready in the 2nd REQ cycle
        issue(2'b10, 1'b0, 1'b1, 1'b1, 32'h4000, 32'h8000_0000);
        chk("t3_pc", pc_a, 32'h8000_0000);
        cycles(1);
        flush = 1'b1; ready = 1'b1;
        cycles(1);
        flush = 1'b0; ready = 1'b0;
        chk("t3_vld", {31'd0, vld_a}, 32'd0);
        chk("t3_cnt", {16'd0, cnt_a}, 32'd2);

        // 4: jal to 0x3002: exception on RVC=0, redirect on RVC=1
        issue(2'b01, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h3002);
        chk("t4_expt", {31'd0, ev_b}, 32'd1);
        chk("t4_tval", tv_b, 32'h3002);
        chk("t4_novld", {31'd0, vld_b}, 32'd0);
        chk("t4_a_vld", {31'd0, vld_a}, 32'd1);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        chk("t4_pulse", {31'd0, ev_b}, 32'd0);

        // 5: stalled mispredict is not captured; then back-to-back while REQ
        stall = 1'b1;
        issue(2'b10, 1'b0, 1'b0, 1'b1, 32'h6000, 32'h7000);
        stall = 1'b0;
        chk("t5_stall", {31'd0, vld_a}, 32'd0);
        issue(2'b10, 1'b0, 1'b0, 1'b1, 32'h6000, 32'h7000);
        issue(2'b01, 1'b0, 1'b0, 1'b1, 32'h6004, 32'h9000);
        chk("t5_wp", {31'd0, wp_a}, 32'd1);
        chk("t5_pc", pc_a, 32'h7000);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        cycles(1);

        // flush in capture cycle, auipc and correct predictions never redirect
        flush = 1'b1;
        issue(2'b10, 1'b0, 1'b0, 1'b1, 32'h6000, 32'h7000);
        flush = 1'b0;
        chk("cap_flush", {31'd0, vld_a}, 32'd0);
        issue(2'b11, 1'b1, 1'b0, 1'b1, 32'h6000, 32'h7002);
        issue(2'b00, 1'b1, 1'b1, 1'b1, 32'h6000, 32'h7000);
        issue(2'b01, 1'b0, 1'b1, 1'b0, 32'h6000, 32'h7000);
        chk("no_redir", {31'd0, vld_a}, 32'd0);

        // 6: four redirects with ready held high saturate the 2-bit counter
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(2'b10, 1'b0, 1'b0, 1'b1, 32'h100 * k, 32'hA000 + 32'h10 * k);
            cycles(1);
        end
        ready = 1'b0;
        chk("t6_sat", {30'd0, cnt_b}, 32'd3);
        chk("t6_cnt_a", {16'd0, cnt_a}, 32'd8);

        // reset while pending
        issue(2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'hB000);
        chk("rq_vld", {31'd0, vld_a}, 32'd1);
        rst_b = 1'b0;
        cycles(1);
        rst_b = 1'b1;
        chk("rs_vld", {31'd0, vld_a}, 32'd0);
        chk("rs_state", {31'd0, st_a}, 32'd0);
        chk("rs_cnt", {30'd0, cnt_b}, 32'd0);
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
